switch_cmd_encoder: RTL and testbench

//   Parametrised successor to the switch-to-command generator. Converts a vector of

---
 rtl/dl_cmd_pkg.sv | 36 +++
 rtl/switch_debouncer.sv | 57 +++++
 rtl/switch_cmd_encoder.sv | 113 +++++++++++
 tb/tb_switch_cmd_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dl_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : dl_cmd_pkg
//  Description: Shared widths, defaults, FSM state type and byte encoder for
//               the switch-to-command path.
//  Revision   : 1.0  initial release
// ============================================================================
package dl_cmd_pkg;

  localparam int CMD_W = 8;
  localparam int TAG_W = 2;
  localparam int VAL_W = CMD_W - TAG_W;

  localparam logic [TAG_W-1:0] DEF_TAG         = 2'b11;
  localparam logic [CMD_W-1:0] DEF_IGNORE_CODE = 8'h03;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Value is zero-extended by the caller, so the pad bits are implicit.
  function automatic logic [CMD_W-1:0] encode(
    input logic [VAL_W-1:0] value,
    input logic [VAL_W-1:0] vmax,
    input logic [TAG_W-1:0] tag,
    input logic [CMD_W-1:0] ignore_code
  );
    if (value > vmax) begin
      return ignore_code;
    end
    return {value, tag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module     : switch_debouncer
//  Description: Two-flop synchroniser followed by a hold-still counter.
//               Emits a single-cycle commit pulse once the synchronised
//               value has been steady for CNT cycles.
//  Revision   : 1.0  initial release
// ============================================================================
module switch_debouncer #(
  parameter int W   = 5,
  parameter int CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] value_o,
  output logic         commit_o
);

  localparam int            CW   = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CNT - 1);

  logic [W-1:0]  sync1_q;
  logic [W-1:0]  sync2_q;
  logic [W-1:0]  cand_q;
  logic [CW-1:0] cnt_q;
  logic          commit_q;

  // Synchronise, restart the count on any change, pulse commit when the count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q   <= sync2_q;
        cnt_q    <= '0;
        commit_q <= 1'b0;
      end else if (cnt_q != LAST) begin
        cnt_q    <= cnt_q + CW'(1);
        commit_q <= ((cnt_q + CW'(1)) == LAST);
      end else begin
        commit_q <= 1'b0;
      end
    end
  end

  assign value_o  = cand_q;
  assign commit_o = commit_q;

endmodule
`default_nettype wire

// File: rtl/switch_cmd_encoder.sv
`default_nettype none
// ============================================================================
//  Module     : switch_cmd_encoder
//  Description: Turns debounced panel switches into tagged command bytes with
//               a valid/ready handshake, a single-deep pending update and an
//               optional periodic resend.
//  Revision   : 1.0  initial release
// ============================================================================
module switch_cmd_encoder
  import dl_cmd_pkg::*;
#(
  parameter int               SW_W         = 5,
  parameter int               DEBOUNCE_CNT = 5_000_000,
  parameter int               VALUE_MAX    = 20,
  parameter logic [TAG_W-1:0] TAG          = DEF_TAG,
  parameter logic [CMD_W-1:0] IGNORE_CODE  = DEF_IGNORE_CODE,
  parameter int               REPEAT_CNT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_in,
  input  logic             tx_ready,
  output logic [CMD_W-1:0] data,
  output logic             data_valid,
  output logic [SW_W-1:0]  stable_val
);

  localparam int            RW       = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
  localparam bit            RPT_EN   = (REPEAT_CNT > 0);
  localparam logic [RW-1:0] RPT_LAST = RW'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);
  localparam logic [VAL_W-1:0] VMAX  = VAL_W'(VALUE_MAX);

  logic [SW_W-1:0]  cand;
  logic             commit;

  state_e           state_q;
  logic [CMD_W-1:0] data_q;
  logic             valid_q;
  logic [SW_W-1:0]  stable_q;
  logic             primed_q;
  logic             pending_q;
  logic [RW-1:0]    timer_q;

  logic             change_evt;
  logic             repeat_evt;
  logic [SW_W-1:0]  load_val;

  switch_debouncer #(
    .W   (SW_W),
    .CNT (DEBOUNCE_CNT)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_in),
    .value_o  (cand),
    .commit_o (commit)
  );

  // The first commit after reset always sends, even if it matches stable_val.
  assign change_evt = commit && ((cand != stable_q) || !primed_q);
  assign repeat_evt = RPT_EN && primed_q && (timer_q == RPT_LAST);
  // Loading in the commit cycle must see the value being committed right now.
  assign load_val   = commit ? cand : stable_q;

  // Commit tracking, handshake FSM, pending flag, repeat timer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stable_q  <= '0;
      primed_q  <= 1'b0;
      pending_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      if (commit) begin
        stable_q <= cand;
        primed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (change_evt || repeat_evt || pending_q) begin
            data_q    <= encode(VAL_W'(load_val), VMAX, TAG, IGNORE_CODE);
            valid_q   <= 1'b1;
            pending_q <= 1'b0;
            timer_q   <= '0;
            state_q   <= SEND;
          end else if (RPT_EN && primed_q) begin
            timer_q <= timer_q + RW'(1);
          end
        end
        SEND: begin
          // Single-deep: a later change simply re-arms the same flag.
          if (change_evt) begin
            pending_q <= 1'b1;
          end
          if (tx_ready) begin
            valid_q <= 1'b0;
            timer_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign stable_val = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_cmd_encoder.sv
`default_nettype none
// ============================================================================
//  Module     : tb_switch_cmd_encoder
//  Description: Scoreboard bench for switch_cmd_encoder; one instance sends on
//               change only, a second one resends every 16 idle cycles.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_switch_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_r;
  logic       tx_ready;
  logic [4:0] sw_in;

  logic [7:0] data,   data_r;
  logic       data_valid, valid_r;
  logic [4:0] stable_val, stable_r;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q  [$];
  logic [7:0] qr [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_cmd_encoder #(
    .SW_W(5), .DEBOUNCE_CNT(4), .VALUE_MAX(20),
    .TAG(2'b11), .IGNORE_CODE(8'h03), .REPEAT_CNT(0)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .tx_ready(tx_ready),
    .data(data), .data_valid(data_valid), .stable_val(stable_val)
  );

  switch_cmd_encoder #(
    .SW_W(5), .DEBOUNCE_CNT(4), .VALUE_MAX(20),
    .TAG(2'b11), .IGNORE_CODE(8'h03), .REPEAT_CNT(16)
  ) dut_rpt (
    .clk(clk), .rst(rst_r), .sw_in(sw_in), .tx_ready(tx_ready),
    .data(data_r), .data_valid(valid_r), .stable_val(stable_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit rpt, output int t);
    bit seen;
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if ((rpt ? valid_r : data_valid) === 1'b1) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
    if (!seen) chk(rpt ? "rpt_valid_timeout" : "valid_timeout", 32'(seen), 32'd1);
  endtask

  // Scoreboard: every accepted byte must match the oldest expected one
  always @(negedge clk) begin
    if (rst === 1'b0 && data_valid === 1'b1 && tx_ready === 1'b1) begin
      if (q.size() == 0) chk("sb_extra", 32'(q.size()), 32'd1);
      else chk("sb_byte", 32'(data), 32'(q.pop_front()));
    end
    if (rst_r === 1'b0 && valid_r === 1'b1 && tx_ready === 1'b1) begin
      if (qr.size() == 0) chk("sbr_extra", 32'(qr.size()), 32'd1);
      else chk("sbr_byte", 32'(data_r), 32'(qr.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cs, t, t0, t1, t2, t3, t4;
    rst = 1'b1; rst_r = 1'b1; tx_ready = 1'b1; sw_in = 5'd0;
    repeat (3) tick();
    chk("rst_data",   32'(data),       32'h00);
    chk("rst_valid",  32'(data_valid), 32'd0);
    chk("rst_stable", 32'(stable_val), 32'd0);

    // 1: first commit always sends; latency 2 sync + 4 debounce + 1 load
    rst = 1'b0; sw_in = 5'd5; cs = cyc; q.push_back(8'h17);
    wait_valid(1'b0, t);
    chk("t1_latency", 32'(t - cs), 32'd7);
    chk("t1_data",    32'(data),   32'h17);
    tick();
    chk("t1_one_cycle", 32'(data_valid), 32'd0);
    chk("t1_stable",    32'(stable_val), 32'd5);

    // 2: short glitch to 7 never commits
    sw_in = 5'd7; tick(); tick(); sw_in = 5'd5;
    repeat (12) tick();
    chk("t2_stable", 32'(stable_val), 32'd5);
    chk("t2_idle",   32'(data_valid), 32'd0);

    // 3: out-of-range value encodes the ignore code
    sw_in = 5'd25; q.push_back(8'h03);
    repeat (10) tick();
    chk("t3_stable", 32'(stable_val), 32'd25);
    chk("t3_data",   32'(data),       32'h03);

    // 4: back-pressure, change during SEND is held pending
    tx_ready = 1'b0; sw_in = 5'd5; q.push_back(8'h17);
    wait_valid(1'b0, t);
    sw_in = 5'd3; q.push_back(8'h0F);
    repeat (10) tick();
    chk("t4_hold_valid", 32'(data_valid), 32'd1);
    chk("t4_hold_data",  32'(data),       32'h17);
    chk("t4_stable",     32'(stable_val), 32'd3);
    tx_ready = 1'b1;
    tick();
    chk("t4_gap_valid", 32'(data_valid), 32'd0);
    chk("t4_gap_data",  32'(data),       32'h17);
    tick();
    chk("t4_pend_valid", 32'(data_valid), 32'd1);
    chk("t4_pend_data",  32'(data),       32'h0F);
    repeat (5) tick();

    // 5: periodic resend every 16 idle cycles; a change restarts the timer
    rst_r = 1'b0; sw_in = 5'd9; q.push_back(8'h27); qr.push_back(8'h27);
    wait_valid(1'b1, t0);
    qr.push_back(8'h27);
    wait_valid(1'b1, t1);
    chk("t5_period1", 32'(t1 - t0), 32'd17);
    chk("t5_stable",  32'(stable_r), 32'd9);
    qr.push_back(8'h27);
    wait_valid(1'b1, t2);
    chk("t5_period2", 32'(t2 - t1), 32'd17);
    sw_in = 5'd4; q.push_back(8'h13); qr.push_back(8'h13);
    wait_valid(1'b1, t3);
    chk("t5_change_lat", 32'(t3 - t2), 32'd7);
    chk("t5_change_data", 32'(data_r), 32'h13);
    qr.push_back(8'h13);
    wait_valid(1'b1, t4);
    chk("t5_period3", 32'(t4 - t3), 32'd17);
    tick();
    rst_r = 1'b1;
    repeat (3) tick();

    // 6: reset in the middle of an offered byte drops it
    tx_ready = 1'b0; sw_in = 5'd6;
    wait_valid(1'b0, t);
    chk("t6_offer", 32'(data), 32'h1B);
    rst = 1'b1;
    tick();
    chk("t6_rst_data",   32'(data),       32'h00);
    chk("t6_rst_valid",  32'(data_valid), 32'd0);
    chk("t6_rst_stable", 32'(stable_val), 32'd0);
    rst = 1'b0; tx_ready = 1'b1; cs = cyc; q.push_back(8'h1B);
    wait_valid(1'b0, t);
    chk("t6_latency", 32'(t - cs), 32'd7);
    repeat (20) tick();

    chk("sb_left",  32'(q.size()),  32'd0);
    chk("sbr_left", 32'(qr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
